// File: rtl/gf2m_stream_mul.sv
// Streaming GF(2^M) multiplier: P = A*B mod g(x), with M = W*N.
// Operands and modulus arrive as N words (MSW first), the product is
// computed bit-serially (D product bits per cycle, MSB first over B) and
// streamed out as N words (MSW first).
//
// Handshakes: a beat moves on a rising edge where valid and ready are both
// high; ready never depends on valid, and a producer holding valid must keep
// its data stable until that edge. in_ready is high only in LOAD and
// out_valid only in OUTPUT, so input and output beats never share a cycle.
module gf2m_stream_mul #(
  parameter int W = 8,
  parameter int N = 21,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] ai,
  input  logic [W-1:0] bi,
  input  logic [W-1:0] gi,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] po,
  output logic         busy,
  output logic [1:0]   state_dbg
);

  localparam int M     = W * N;
  localparam int STEPS = M / D;
  localparam int CMAX  = (N > STEPS) ? N : STEPS;
  localparam int CW    = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] LAST_WORD = CW'(N - 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  if ((M % D) != 0) begin : g_bad_d
    $error("gf2m_stream_mul: W*N must be a multiple of D");
  end

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;     // word index in LOAD/OUTPUT, step index in COMPUTE
  logic [M-1:0]  a_q;
  logic [M-1:0]  b_q;     // shifted left each step; MSB is the current B bit
  logic [M-1:0]  g_q;
  logic [M-1:0]  p_q;     // accumulator, then output shift register
  logic [M-1:0]  p_step;
  logic [M-1:0]  b_step;
  logic [M-1:0]  ai_ext;
  logic [M-1:0]  bi_ext;
  logic [M-1:0]  gi_ext;

  assign ai_ext = M'(ai);
  assign bi_ext = M'(bi);
  assign gi_ext = M'(gi);

  // D interleaved multiply/reduce iterations: the bit shifted out of P
  // (x^M) folds back as g, and the current B bit adds A.
  always_comb begin
    p_step = p_q;
    b_step = b_q;
    for (int i = 0; i < D; i++) begin
      p_step = (p_step << 1) ^ (p_step[M-1] ? g_q : '0) ^ (b_step[M-1] ? a_q : '0);
      b_step = b_step << 1;
    end
  end

  // Control FSM plus all datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      g_q   <= '0;
      p_q   <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          if (in_valid) begin
            a_q <= (a_q << W) | ai_ext;
            b_q <= (b_q << W) | bi_ext;
            g_q <= (g_q << W) | gi_ext;
            if (cnt == LAST_WORD) begin
              cnt   <= '0;
              p_q   <= '0;
              state <= COMPUTE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        COMPUTE: begin
          p_q <= p_step;
          b_q <= b_step;
          if (cnt == LAST_STEP) begin
            cnt   <= '0;
            state <= OUTPUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            p_q <= p_q << W;
            if (cnt == LAST_WORD) begin
              cnt   <= '0;
              state <= LOAD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          cnt   <= '0;
          state <= LOAD;
        end
      endcase
    end
  end

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == OUTPUT);
  assign busy      = (state != LOAD);
  assign po        = (state == OUTPUT) ? p_q[M-1 -: W] : '0;
  assign state_dbg = state;

endmodule

// File: tb/tb_gf2m_stream_mul.sv
// Bench for gf2m_stream_mul: N=1 instances at D=1,2,4,8 sharing stimulus,
// an N=2 instance, and a default-parameter (N=21, GF(2^168)) instance.
`timescale 1ns/1ps
module tb_gf2m_stream_mul;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- N=1 group (D = 1,2,4,8) ----------------
  logic       s_valid, s_rdy;
  logic [7:0] s_a, s_b, s_g;
  logic [3:0] s_in_ready, s_out_valid, s_busy;
  logic [7:0] s_po [4];
  logic [1:0] s_state [4];

  for (genvar k = 0; k < 4; k++) begin : g_small
    gf2m_stream_mul #(.W(8), .N(1), .D(1 << k)) u_dut (
      .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s_in_ready[k]),
      .ai(s_a), .bi(s_b), .gi(s_g), .out_valid(s_out_valid[k]),
      .out_ready(s_rdy), .po(s_po[k]), .busy(s_busy[k]), .state_dbg(s_state[k])
    );
  end

  // ---------------- N=2 instance ----------------
  logic       m_valid, m_rdy, m_in_ready, m_out_valid, m_busy;
  logic [7:0] m_a, m_b, m_g, m_po;
  logic [1:0] m_state;

  gf2m_stream_mul #(.W(8), .N(2), .D(1)) u_n2 (
    .clk(clk), .rst(rst), .in_valid(m_valid), .in_ready(m_in_ready),
    .ai(m_a), .bi(m_b), .gi(m_g), .out_valid(m_out_valid),
    .out_ready(m_rdy), .po(m_po), .busy(m_busy), .state_dbg(m_state)
  );

  // ---------------- default instance (W=8, N=21, D=1) ----------------
  logic       l_valid, l_rdy, l_in_ready, l_out_valid, l_busy;
  logic [7:0] l_a, l_b, l_g, l_po;
  logic [1:0] l_state;

  gf2m_stream_mul u_big (
    .clk(clk), .rst(rst), .in_valid(l_valid), .in_ready(l_in_ready),
    .ai(l_a), .bi(l_b), .gi(l_g), .out_valid(l_out_valid),
    .out_ready(l_rdy), .po(l_po), .busy(l_busy), .state_dbg(l_state)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] p;
  } vec_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] g;
    logic [15:0] p;
  } vec16_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference: full carry-less product, then long division by x^m + g.
  function automatic logic [167:0] gf_ref(input logic [167:0] a, input logic [167:0] b,
                                         input logic [167:0] g, input int m);
    logic [335:0] prod;
    logic [335:0] full;
    prod = '0;
    for (int i = 0; i < m; i++)
      if (b[i]) prod ^= ({168'b0, a} << i);
    full = {168'b0, g};
    full[m] = 1'b1;
    for (int i = 2 * m - 2; i >= m; i--)
      if (prod[i]) prod ^= (full << (i - m));
    return prod[167:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_small(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] g, input logic [7:0] exp);
    int lat [4];
    s_a = a; s_b = b; s_g = g; s_valid = 1'b1; s_rdy = 1'b0;
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_a = 8'($urandom); s_b = 8'($urandom); s_g = 8'($urandom);
    for (int k = 0; k < 4; k++) lat[k] = -1;
    for (int e = 0; e <= 20; e++) begin
      for (int k = 0; k < 4; k++)
        if (lat[k] < 0 && s_out_valid[k]) lat[k] = e;
      if (&s_out_valid) break;
      @(posedge clk); #1;
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s latency D=%0d", name, 1 << k), 64'(lat[k]), 64'(8 >> k));
      check($sformatf("%s po D=%0d", name, 1 << k), s_po[k], exp);
      check($sformatf("%s in_ready busy D=%0d", name, 1 << k), s_in_ready[k], 1'b0);
    end
    s_rdy = 1'b1;
    @(posedge clk); #1;
    s_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s in_ready after D=%0d", name, 1 << k), s_in_ready[k], 1'b1);
      check($sformatf("%s out_valid after D=%0d", name, 1 << k), s_out_valid[k], 1'b0);
    end
  endtask

  task automatic run_n2(input string name, input vec16_t v);
    int lat;
    for (int w = 0; w < 2; w++) begin
      m_a = v.a[15 - 8 * w -: 8];
      m_b = v.b[15 - 8 * w -: 8];
      m_g = v.g[15 - 8 * w -: 8];
      m_valid = 1'b1;
      @(posedge clk); #1;
    end
    m_valid = 1'b0;
    lat = -1;
    for (int e = 0; e <= 40; e++) begin
      if (m_out_valid) begin lat = e; break; end
      @(posedge clk); #1;
    end
    check({name, " latency"}, 64'(lat), 64'd16);
    for (int w = 0; w < 2; w++) begin
      check($sformatf("%s beat%0d", name, w), m_po, v.p[15 - 8 * w -: 8]);
      m_rdy = 1'b1;
      @(posedge clk); #1;
      m_rdy = 1'b0;
    end
    check({name, " in_ready after"}, m_in_ready, 1'b1);
  endtask

  task automatic run_large(input int op);
    logic [167:0] a, b, g, p;
    logic [7:0]   prev_po, exp_w;
    logic         rdy_pre, stalled;
    int           idx, guard;
    for (int i = 0; i < 6; i++) begin
      a = {a[135:0], 32'($urandom)};
      b = {b[135:0], 32'($urandom)};
      g = {g[135:0], 32'($urandom)};
    end
    p = gf_ref(a, b, g, 168);
    for (int w = 0; w < 21; w++) exp_q.push_back(p[167 - 8 * w -: 8]);

    check($sformatf("big%0d in_ready load", op), l_in_ready, 1'b1);
    idx = 0; guard = 0;
    while (idx < 21 && guard < 500) begin
      l_valid = ($urandom_range(0, 2) != 0);
      l_a = a[167 - 8 * idx -: 8];
      l_b = b[167 - 8 * idx -: 8];
      l_g = g[167 - 8 * idx -: 8];
      rdy_pre = l_in_ready;
      @(posedge clk); #1;
      guard++;
      if (l_valid && rdy_pre) idx++;
    end
    check($sformatf("big%0d load words", op), 64'(idx), 64'd21);

    // Keep in_valid high with junk while busy: it must be ignored.
    l_valid = 1'b1; stalled = 1'b0; prev_po = '0; guard = 0;
    while (exp_q.size() > 0 && guard < 2000) begin
      l_a = 8'($urandom); l_b = 8'($urandom); l_g = 8'($urandom);
      check($sformatf("big%0d in_ready busy", op), l_in_ready, 1'b0);
      if (stalled) begin
        check($sformatf("big%0d stall po", op), l_po, prev_po);
        check($sformatf("big%0d stall valid", op), l_out_valid, 1'b1);
      end
      l_rdy = 1'($urandom_range(0, 1));
      if (l_out_valid && l_rdy) begin
        exp_w = exp_q.pop_front();
        check($sformatf("big%0d po", op), l_po, exp_w);
        if (exp_q.size() == 0) l_valid = 1'b0;
      end
      stalled = l_out_valid && !l_rdy;
      prev_po = l_po;
      @(posedge clk); #1;
      guard++;
    end
    check($sformatf("big%0d words left", op), 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    l_valid = 1'b0; l_rdy = 1'b0;
    check($sformatf("big%0d in_ready after", op), l_in_ready, 1'b1);
    check($sformatf("big%0d busy after", op), l_busy, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t       tbl [8];
    vec16_t     t16 [2];
    logic [167:0] r;

    rst = 1'b1;
    s_valid = 1'b0; s_rdy = 1'b0; s_a = '0; s_b = '0; s_g = '0;
    m_valid = 1'b0; m_rdy = 1'b0; m_a = '0; m_b = '0; m_g = '0;
    l_valid = 1'b0; l_rdy = 1'b0; l_a = '0; l_b = '0; l_g = '0;
    #12;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("reset in_ready D=%0d", 1 << k), s_in_ready[k], 1'b1);
      check($sformatf("reset out_valid D=%0d", 1 << k), s_out_valid[k], 1'b0);
      check($sformatf("reset busy D=%0d", 1 << k), s_busy[k], 1'b0);
      check($sformatf("reset po D=%0d", 1 << k), s_po[k], 8'h00);
      check($sformatf("reset state D=%0d", 1 << k), s_state[k], 2'd0);
    end
    check("reset n2 in_ready", m_in_ready, 1'b1);
    check("reset big in_ready", l_in_ready, 1'b1);
    check("reset big po", l_po, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;

    // Fixed AES-field vectors followed by random ones from the model.
    tbl[0] = '{8'h57, 8'h83, 8'h1B, 8'hC1};
    tbl[1] = '{8'h57, 8'h13, 8'h1B, 8'hFE};
    tbl[2] = '{8'h80, 8'h02, 8'h1B, 8'h1B};
    tbl[3] = '{8'h01, 8'hA5, 8'h1B, 8'hA5};
    tbl[4] = '{8'h00, 8'hFF, 8'h1B, 8'h00};
    for (int i = 5; i < 8; i++) begin
      tbl[i].a = 8'($urandom);
      tbl[i].b = 8'($urandom);
      tbl[i].g = 8'($urandom);
      r = gf_ref({160'b0, tbl[i].a}, {160'b0, tbl[i].b}, {160'b0, tbl[i].g}, 8);
      tbl[i].p = r[7:0];
    end
    for (int i = 0; i < 8; i++)
      run_small($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].g, tbl[i].p);

    // Reset in the middle of an operation, then a fresh operation.
    s_a = 8'h57; s_b = 8'h83; s_g = 8'h1B; s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("midrst in_ready D=%0d", 1 << k), s_in_ready[k], 1'b1);
      check($sformatf("midrst out_valid D=%0d", 1 << k), s_out_valid[k], 1'b0);
      check($sformatf("midrst busy D=%0d", 1 << k), s_busy[k], 1'b0);
      check($sformatf("midrst po D=%0d", 1 << k), s_po[k], 8'h00);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    run_small("after_rst", 8'h57, 8'h83, 8'h1B, 8'hC1);

    // N=2 corner cases.
    t16[0] = '{16'h8000, 16'h0002, 16'h002B, 16'h002B};
    t16[1] = '{16'h0001, 16'h0002, 16'h002B, 16'h0002};
    for (int i = 0; i < 2; i++) run_n2($sformatf("n2_%0d", i), t16[i]);

    // GF(2^168) random operations with gaps and stalls.
    for (int op = 0; op < 3; op++) run_large(op);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gf2m_stream_mul.md
GF2M_STREAM_MUL -- requirements
Module: gf2m_stream_mul

Interface
REQ-001 Parameter W, default 8: word width in bits of ai, bi, gi, po.
REQ-002 Parameter N, default 21: words per operand; field degree M = W*N.
REQ-003 Parameter D, default 1: product bits processed per compute cycle; M mod D = 0 is required (elaboration error otherwise).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  ai/bi/gi beat valid.
REQ-007 in_ready  output  1  block accepts a beat.
REQ-008 ai  input  W  operand A word, most-significant word first.
REQ-009 bi  input  W  operand B word, MSW first.
REQ-010 gi  input  W  modulus word, MSW first; low M bits of g(x), x^M implicit.
REQ-011 out_valid  output  1  po word valid.
REQ-012 out_ready  input  1  consumer accepts po.
REQ-013 po  output  W  product word P = A*B mod g, MSW first.
REQ-014 busy  output  1  high in COMPUTE or OUTPUT.

Function
REQ-015 States LOAD, COMPUTE, OUTPUT; reset state LOAD.
REQ-016 LOAD: in_ready=1; beat accepted on edge with in_valid=1; word counter increments; A/B/G registers shift left W bits, new word into LSBs.
REQ-017 LOAD with in_valid=0: counter and registers hold; no timeout.
REQ-018 Nth accepted beat: counter clears, P cleared, state -> COMPUTE on the same edge.
REQ-019 COMPUTE: in_ready=0; per edge D iterations MSB-first over B: t=P[M-1]; P=(P<<1) mod 2^M; if t, P^=G; if current B bit, P^=A; bit index descends M-1..0.
REQ-020 COMPUTE lasts exactly M/D edges; out_valid high from the (M/D)th edge after the edge accepting the last input beat.
REQ-021 OUTPUT: out_valid=1; po = P[M-1 -: W] of current output shift register; on edge with out_ready=1, register shifts left W, counter increments.
REQ-022 out_ready=0 in OUTPUT: po and out_valid hold stable, no data loss.
REQ-023 Nth output beat accepted: state -> LOAD, in_ready=1 next cycle; no same-cycle overlap of input and output beats.
REQ-024 in_valid during COMPUTE/OUTPUT is ignored; ai/bi/gi not sampled.
REQ-025 Arithmetic carry-free (XOR only); no widths beyond M bits stored except one overflow bit per iteration.
REQ-026 N=1 supported: one beat per operand, one output beat.

Reset
REQ-027 rst high, any state, any cycle: immediately state=LOAD, counters 0, A/B/G/P 0, in_ready=1, out_valid=0, busy=0, po=0.
REQ-028 Reset mid-LOAD, mid-COMPUTE or mid-OUTPUT discards partial operands/result; next operation starts from word 0.
REQ-029 First edge after rst falls behaves as ordinary LOAD edge.

Verification
REQ-030 W=8,N=1,D=1, g=0x1B, A=0x57, B=0x83 -> po=0xC1, out_valid rises 8 edges after accepting beat.
REQ-031 Same config, A=0x57, B=0x13 -> 0xFE; then D=2,4,8 builds give identical results with out_valid at 4/2/1 edges.
REQ-032 W=8,N=2, g=0x002B (words 0x00,0x2B), A=0x8000, B=0x0002 -> po beats 0x00 then 0x2B; A=0x0001,B=0x0002 -> 0x00,0x02.
REQ-033 W=8,N=21: random A,B, g=x^168 low bits from gi words, gapped in_valid and random out_ready stalls -> po matches software GF(2^168) model, po stable while stalled.
REQ-034 rst pulsed mid-COMPUTE then fresh 0x57*0x83 (W=8,N=1) -> outputs return to reset values asynchronously; next result 0xC1, no stale beat.
REQ-035 in_valid held high throughout COMPUTE/OUTPUT with changing data -> result unaffected; in_ready=0 in those states.
